uart_frame_parser: RTL and testbench

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_parser.sv | 155 +++++++++++++++
 tb/tb_uart_frame_parser.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser: 55 AA LEN payload CHK, CHK = (LEN + sum of payload) mod 256.
// Optional inter-byte timeout enabled with macro UART_FRAME_TIMEOUT_EN.
module uart_frame_parser #(
   parameter logic [31:0] CLK_FREQ      = 32'd50_000_000,
   parameter logic [31:0] BAUDRATE      = 32'd115_200,
   parameter logic [7:0]  HEADER0       = 8'h55,
   parameter logic [7:0]  HEADER1       = 8'hAA,
   parameter logic [7:0]  MAX_LEN       = 8'd64,
   parameter logic [31:0] TIMEOUT_BYTES = 32'd4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_valid_i,
   input  logic [7:0] rx_data_i,
   output logic       payload_valid_o,
   output logic [7:0] payload_data_o,
   output logic       payload_sop_o,
   output logic       payload_eop_o,
   output logic       frame_ok_o,
   output logic       frame_err_o,
   output logic [1:0] err_code_o
);

   typedef enum logic [2:0] {ST_IDLE, ST_HDR1, ST_LEN, ST_DATA, ST_CHK} state_t;

   state_t     state, state_next;
   logic [7:0] acc, acc_next;
   logic [7:0] remain, remain_next;
   logic       first, first_next;
   logic       pv_next, sop_next, eop_next, ok_next, err_next;
   logic [1:0] code_next;
   logic       len_bad;
   logic       tmo_hit;

   assign len_bad = (rx_data_i == 8'd0) || (rx_data_i > MAX_LEN);

`ifdef UART_FRAME_TIMEOUT_EN
   localparam logic [31:0] TMO_LIMIT = TIMEOUT_BYTES * 32'd10 * (CLK_FREQ / BAUDRATE);
   logic [31:0] tmo_cnt;

   // A byte arriving on the limit cycle wins over the timeout.
   assign tmo_hit = (state != ST_IDLE) && !rx_valid_i && (tmo_cnt == TMO_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tmo_cnt <= '0;
      else if (state == ST_IDLE || rx_valid_i)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + 32'd1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (rx_valid_i) begin
         case (state)
            ST_IDLE: if (rx_data_i == HEADER0) state_next = ST_HDR1;
            ST_HDR1: begin
               if (rx_data_i == HEADER1)      state_next = ST_LEN;
               else if (rx_data_i == HEADER0) state_next = ST_HDR1;
               else                           state_next = ST_IDLE;
            end
            ST_LEN:  state_next = len_bad ? ST_IDLE : ST_DATA;
            ST_DATA: if (remain == 8'd1) state_next = ST_CHK;
            ST_CHK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
         endcase
      end else if (tmo_hit) begin
         state_next = ST_IDLE;
      end
   end

   always_comb begin
      acc_next    = acc;
      remain_next = remain;
      first_next  = first;
      pv_next     = 1'b0;
      sop_next    = 1'b0;
      eop_next    = 1'b0;
      ok_next     = 1'b0;
      err_next    = 1'b0;
      code_next   = 2'd0;
      if (rx_valid_i) begin
         case (state)
            ST_LEN: begin
               if (len_bad) begin
                  err_next  = 1'b1;
                  code_next = 2'd1;
               end else begin
                  acc_next    = rx_data_i;
                  remain_next = rx_data_i;
                  first_next  = 1'b1;
               end
            end
            ST_DATA: begin
               acc_next    = acc + rx_data_i;
               remain_next = remain - 8'd1;
               first_next  = 1'b0;
               pv_next     = 1'b1;
               sop_next    = first;
               eop_next    = (remain == 8'd1);
            end
            ST_CHK: begin
               if (rx_data_i == acc) begin
                  ok_next = 1'b1;
               end else begin
                  err_next  = 1'b1;
                  code_next = 2'd2;
               end
            end
            default: ;
         endcase
      end else if (tmo_hit) begin
         err_next  = 1'b1;
         code_next = 2'd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc             <= '0;
         remain          <= '0;
         first           <= 1'b0;
         payload_valid_o <= 1'b0;
         payload_data_o  <= '0;
         payload_sop_o   <= 1'b0;
         payload_eop_o   <= 1'b0;
         frame_ok_o      <= 1'b0;
         frame_err_o     <= 1'b0;
         err_code_o      <= '0;
      end else begin
         acc             <= acc_next;
         remain          <= remain_next;
         first           <= first_next;
         payload_valid_o <= pv_next;
         payload_data_o  <= pv_next ? rx_data_i : 8'd0;
         payload_sop_o   <= sop_next;
         payload_eop_o   <= eop_next;
         frame_ok_o      <= ok_next;
         frame_err_o     <= err_next;
         err_code_o      <= code_next;
      end
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser; timeout case built only with UART_FRAME_TIMEOUT_EN.
module tb_uart_frame_parser;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       payload_valid, payload_sop, payload_eop, frame_ok, frame_err;
   logic [7:0] payload_data;
   logic [1:0] err_code;

   int unsigned checks = 0;
   int unsigned failures = 0;

   logic [7:0] pd[$];
   logic       ps[$];
   logic       pe[$];
   int unsigned ok_n = 0, err_n = 0, stray = 0;
   logic [1:0]  last_code = 2'd0;
   int unsigned b_p, b_ok, b_err;

   uart_frame_parser #(
      .CLK_FREQ(32'd50_000_000),
      .BAUDRATE(32'd115_200),
      .HEADER0(8'h55),
      .HEADER1(8'hAA),
      .MAX_LEN(8'd64),
      .TIMEOUT_BYTES(32'd4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx_valid_i(rx_valid),
      .rx_data_i(rx_data),
      .payload_valid_o(payload_valid),
      .payload_data_o(payload_data),
      .payload_sop_o(payload_sop),
      .payload_eop_o(payload_eop),
      .frame_ok_o(frame_ok),
      .frame_err_o(frame_err),
      .err_code_o(err_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (payload_valid) begin
         pd.push_back(payload_data);
         ps.push_back(payload_sop);
         pe.push_back(payload_eop);
      end
      if (frame_ok) ok_n++;
      if (frame_err) begin
         err_n++;
         last_code = err_code;
      end
      if (err_code != 2'd0 && !frame_err) stray++;
      if (!payload_valid && (payload_sop || payload_eop)) stray++;
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic mark();
      b_p   = pd.size();
      b_ok  = ok_n;
      b_err = err_n;
   endtask

   task automatic expect_frame(input string tag, input int unsigned np, input int unsigned nok,
                               input int unsigned nerr, input logic [1:0] code);
      idle(4);
      chk_eq({tag, "_payload_cnt"}, pd.size() - b_p, np);
      chk_eq({tag, "_ok_cnt"}, ok_n - b_ok, nok);
      chk_eq({tag, "_err_cnt"}, err_n - b_err, nerr);
      if (nerr != 0) chk_eq({tag, "_err_code"}, {30'd0, last_code}, {30'd0, code});
   endtask

   task automatic expect_byte(input string tag, input int unsigned idx, input logic [7:0] d,
                              input logic s, input logic e);
      if (idx < pd.size()) begin
         chk_eq({tag, "_data"}, {24'd0, pd[idx]}, {24'd0, d});
         chk_eq({tag, "_sop"}, {31'd0, ps[idx]}, {31'd0, s});
         chk_eq({tag, "_eop"}, {31'd0, pe[idx]}, {31'd0, e});
      end else begin
         chk_eq({tag, "_present"}, 32'd0, 32'd1);
      end
   endtask

   initial begin
      idle(3);
      chk_eq("rst_valid", {31'd0, payload_valid}, 32'd0);
      chk_eq("rst_data", {24'd0, payload_data}, 32'd0);
      chk_eq("rst_flags", {28'd0, payload_sop, payload_eop, frame_ok, frame_err}, 32'd0);
      chk_eq("rst_code", {30'd0, err_code}, 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Good 3-byte frame
      mark();
      send(8'h55); send(8'hAA); send(8'h03);
      send(8'h11); send(8'h22); send(8'h33); send(8'h69);
      expect_frame("f3", 3, 1, 0, 2'd0);
      expect_byte("f3_b0", b_p + 0, 8'h11, 1'b1, 1'b0);
      expect_byte("f3_b1", b_p + 1, 8'h22, 1'b0, 1'b0);
      expect_byte("f3_b2", b_p + 2, 8'h33, 1'b0, 1'b1);

      // Checksum mismatch: expected 05, sent 00
      mark();
      send(8'h55); send(8'hAA); send(8'h02); send(8'h01); send(8'h02); send(8'h00);
      expect_frame("chk", 2, 0, 1, 2'd2);
      expect_byte("chk_b0", b_p + 0, 8'h01, 1'b1, 1'b0);
      expect_byte("chk_b1", b_p + 1, 8'h02, 1'b0, 1'b1);

      // Length zero and length MAX_LEN+1
      mark();
      send(8'h55); send(8'hAA); send(8'h00);
      expect_frame("len0", 0, 0, 1, 2'd1);
      mark();
      send(8'h55); send(8'hAA); send(8'h41);
      expect_frame("len41", 0, 0, 1, 2'd1);

      // Repeated header, LEN=1, checksum wraps to 00
      mark();
      send(8'h55); send(8'h55); send(8'hAA); send(8'h01); send(8'hFF); send(8'h00);
      expect_frame("wrap", 1, 1, 0, 2'd0);
      expect_byte("wrap_b0", b_p, 8'hFF, 1'b1, 1'b1);

`ifdef UART_FRAME_TIMEOUT_EN
      begin
         int unsigned n;
         n = 0;
         mark();
         send(8'h55); send(8'hAA); send(8'h02); send(8'h10);
         while (!frame_err && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
         end
         chk_eq("tmo_seen", {31'd0, frame_err}, 32'd1);
         chk_eq("tmo_code", {30'd0, err_code}, 32'd3);
         chk_eq("tmo_window", {31'd0, (n >= 17360 && n <= 17362)}, 32'd1);
         expect_frame("tmo", 1, 0, 1, 2'd3);
         mark();
         send(8'h55); send(8'hAA); send(8'h01); send(8'h05); send(8'h06);
         expect_frame("post_tmo", 1, 1, 0, 2'd0);
      end
`endif

      // Reset mid-DATA abandons the frame silently
      send(8'h55); send(8'hAA); send(8'h03); send(8'h11);
      rst_n = 1'b0;
      #1;
      chk_eq("mid_rst_valid", {31'd0, payload_valid}, 32'd0);
      idle(3);
      rst_n = 1'b1;
      idle(2);
      mark();
      send(8'h55); send(8'hAA); send(8'h01); send(8'h07); send(8'h08);
      expect_frame("post_rst", 1, 1, 0, 2'd0);
      expect_byte("post_rst_b0", b_p, 8'h07, 1'b1, 1'b1);

      chk_eq("stray_flags", stray, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
